// File: rtl/nn_pkg.sv
// Shared defaults and state encoding for the argmax layer block.
// The optional max_out port is controlled by the ARGMAX_VALUE_OUT_EN macro in the top module.
package nn_pkg;

    localparam int T_DEF  = 20;
    localparam int M_DEF  = 12;
    localparam int IW_DEF = $clog2(M_DEF);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Signed strict greater-than compare between a candidate word and the current best.
module argmax_cmp #(
    parameter int T = 20
) (
    input  logic signed [T-1:0] candidate,
    input  logic signed [T-1:0] best,
    output logic                greater
);

    // A strict compare makes ties keep the earlier (lower) index.
    assign greater = (candidate > best);

endmodule

// File: rtl/argmax_12_20.sv
// Streaming argmax over M signed words per vector, with a one-deep registered result handshake.
// Define ARGMAX_VALUE_OUT_EN to expose the maximum value on max_out.
//
// state | meaning
// ACCUM | accepting words of the current vector, s_ready=1
// HOLD  | result registered and offered downstream, m_valid=1
module argmax_12_20
    import nn_pkg::*;
#(
    parameter int T  = T_DEF,
    parameter int M  = M_DEF,
    parameter int IW = $clog2(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [T-1:0] data_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [IW-1:0]       data_out
`ifdef ARGMAX_VALUE_OUT_EN
    ,
    output logic signed [T-1:0] max_out
`endif
);

    state_t              state;
    logic [IW-1:0]       cnt;
    logic signed [T-1:0] best_val;
    logic                s_ready_q;
    logic                greater;
    logic                take;

    // Gating with reset keeps s_ready low for the whole reset window.
    assign s_ready = s_ready_q & reset;
    assign take    = s_valid & s_ready;

    argmax_cmp #(.T(T)) u_cmp (
        .candidate (data_in),
        .best      (best_val),
        .greater   (greater)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ACCUM;
            cnt       <= '0;
            s_ready_q <= 1'b1;
            m_valid   <= 1'b0;
            data_out  <= '0;
            best_val  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (take) begin
                        if ((cnt == '0) || greater) begin
                            best_val <= data_in;
                            data_out <= cnt;
                        end
                        if (cnt == IW'(M - 1)) begin
                            cnt       <= '0;
                            state     <= HOLD;
                            s_ready_q <= 1'b0;
                            m_valid   <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state     <= ACCUM;
                        s_ready_q <= 1'b1;
                        m_valid   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef ARGMAX_VALUE_OUT_EN
    assign max_out = best_val;
`endif

endmodule

// File: tb/tb_argmax_12_20.sv
// Randomized self-checking bench for argmax_12_20 against a plain-loop argmax reference.
// Checks max_out as well when ARGMAX_VALUE_OUT_EN is defined.
module tb_argmax_12_20;

    localparam int T  = 20;
    localparam int M  = 12;
    localparam int IW = 4;

    typedef logic signed [T-1:0] word_t;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [T-1:0]  data_in;
    logic          m_valid;
    logic          m_ready;
    logic [IW-1:0] data_out;
`ifdef ARGMAX_VALUE_OUT_EN
    logic [T-1:0]  max_out;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    argmax_12_20 dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .data_in  (data_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .data_out (data_out)
`ifdef ARGMAX_VALUE_OUT_EN
        ,
        .max_out  (max_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int golden_idx(input word_t v[M]);
        int b = 0;
        for (int i = 1; i < M; i++)
            if (v[i] > v[b]) b = i;
        return b;
    endfunction

    function automatic word_t rand_word();
        logic [T-1:0] w;
        if ($urandom_range(0, 2) == 0) w = T'($urandom_range(0, 6)) - T'(3);
        else                           w = T'($urandom);
        return word_t'(w);
    endfunction

    // Drives words first..last-1 of v, honouring s_ready; leaves s_valid low.
    task automatic send_words(input word_t v[M], input bit rand_valid,
                              input int first, input int last, output bit timed_out);
        int k = first;
        int guard = 0;
        bit acc;
        while (k < last && guard < 2000) begin
            @(negedge clk);
            m_ready = 1'b0;
            s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            data_in = s_valid ? v[k] : 'x;
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) k++;
            guard++;
        end
        #1 s_valid = 1'b0;
        timed_out = (k < last);
    endtask

    task automatic handoff(input bit rand_ready, output bit timed_out);
        int guard = 0;
        bit done = 1'b0;
        while (!done && guard < 200) begin
            @(negedge clk);
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            done = m_ready && m_valid;
            @(posedge clk);
            guard++;
        end
        #1 m_ready = 1'b0;
        timed_out = !done;
    endtask

    task automatic test_reset();
        reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b0) begin n_miss++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        n_vec++; if (m_valid !== 1'b0) begin n_miss++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_vec++; if (data_out !== '0) begin n_miss++; $display("FAIL reset_data_out got %0d want 0", data_out); end
`ifdef ARGMAX_VALUE_OUT_EN
        n_vec++; if (max_out !== '0) begin n_miss++; $display("FAIL reset_max_out got %h want 0", max_out); end
`endif
        reset = 1'b1;
        #1;
        n_vec++; if (s_ready !== 1'b1) begin n_miss++; $display("FAIL post_reset_s_ready got %b want 1", s_ready); end
    endtask

    task automatic test_directed();
        word_t v[M];
        int    exp_idx[5] = '{7, 0, 3, 11, 0};
        logic [T-1:0] exp_max[5] = '{20'h00FFF, 20'h00005, 20'hFFFFB, 20'h7FFFF, 20'h80000};
        bit    to;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < M; k++) begin
                case (c)
                    0: v[k] = (k == 7) ? 20'sh00FFF : word_t'(k * 16);
                    1: v[k] = 20'sh00005;
                    2: v[k] = (k == 3) ? -20'sd5 : -20'sd100;
                    3: v[k] = (k == 0) ? 20'sh80000 : (k == 11) ? 20'sh7FFFF : '0;
                    default: v[k] = 20'sh80000;
                endcase
            end
            send_words(v, 1'b0, 0, M, to);
            n_vec++; if (to) begin n_miss++; $display("FAIL dir%0d_send timeout", c); end
            @(negedge clk);
            n_vec++; if (m_valid !== 1'b1) begin n_miss++; $display("FAIL dir%0d_latency m_valid got %b want 1", c, m_valid); end
            n_vec++; if (s_ready !== 1'b0) begin n_miss++; $display("FAIL dir%0d_hold_s_ready got %b want 0", c, s_ready); end
            n_vec++; if (data_out !== IW'(exp_idx[c])) begin n_miss++; $display("FAIL dir%0d_index got %0d want %0d", c, data_out, exp_idx[c]); end
`ifdef ARGMAX_VALUE_OUT_EN
            n_vec++; if (max_out !== exp_max[c]) begin n_miss++; $display("FAIL dir%0d_max got %h want %h", c, max_out, exp_max[c]); end
`endif
            handoff(1'b0, to);
            n_vec++; if (to) begin n_miss++; $display("FAIL dir%0d_handoff timeout", c); end
            @(negedge clk);
            n_vec++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                n_miss++; $display("FAIL dir%0d_after_handoff m_valid %b s_ready %b want 0 1", c, m_valid, s_ready);
            end
        end
    endtask

    task automatic test_hold();
        word_t v[M];
        int    g;
        bit    to;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < M; k++) v[k] = rand_word();
            g = golden_idx(v);
            send_words(v, 1'b1, 0, M, to);
            n_vec++; if (to) begin n_miss++; $display("FAIL hold%0d_send timeout", c); end
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                m_ready = 1'b0;
                s_valid = 1'($urandom_range(0, 1));
                data_in = T'($urandom);
                n_vec++; if (s_ready !== 1'b0 || m_valid !== 1'b1 || data_out !== IW'(g)) begin
                    n_miss++;
                    $display("FAIL hold%0d_cycle%0d s_ready %b m_valid %b index %0d want 0 1 %0d", c, i, s_ready, m_valid, data_out, g);
                end
`ifdef ARGMAX_VALUE_OUT_EN
                n_vec++; if (max_out !== v[g]) begin n_miss++; $display("FAIL hold%0d_max got %h want %h", c, max_out, v[g]); end
`endif
            end
            s_valid = 1'b0;
            handoff(1'b0, to);
            n_vec++; if (to) begin n_miss++; $display("FAIL hold%0d_handoff timeout", c); end
        end
    endtask

    task automatic test_reset_mid();
        word_t v[M];
        bit    to;
        for (int k = 0; k < M; k++) v[k] = rand_word();
        send_words(v, 1'b0, 0, 5, to);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (s_ready !== 1'b0) begin n_miss++; $display("FAIL mid_reset_s_ready got %b want 0", s_ready); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < M; k++) v[k] = word_t'($urandom_range(0, 1000)) - 20'sd500;
        v[2] = 20'sd4000;
        send_words(v, 1'b1, 0, M - 1, to);
        @(negedge clk);
        n_vec++; if (m_valid !== 1'b0) begin n_miss++; $display("FAIL mid_stale_result m_valid got %b want 0", m_valid); end
        send_words(v, 1'b1, M - 1, M, to);
        n_vec++; if (to) begin n_miss++; $display("FAIL mid_send timeout"); end
        @(negedge clk);
        n_vec++; if (m_valid !== 1'b1 || data_out !== IW'(2)) begin
            n_miss++; $display("FAIL mid_index m_valid %b index %0d want 1 2", m_valid, data_out);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_miss++; $display("FAIL hold_reset m_valid %b s_ready %b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_random();
        word_t v[M];
        int    g;
        bit    to;
        for (int c = 0; c < 1000; c++) begin
            for (int k = 0; k < M; k++) v[k] = rand_word();
            g = golden_idx(v);
            send_words(v, 1'b1, 0, M, to);
            @(negedge clk);
            n_vec++; if (to || m_valid !== 1'b1 || data_out !== IW'(g)) begin
                n_miss++; $display("FAIL rand%0d timeout %b m_valid %b index %0d want %0d", c, to, m_valid, data_out, g);
            end
`ifdef ARGMAX_VALUE_OUT_EN
            n_vec++; if (max_out !== v[g]) begin n_miss++; $display("FAIL rand%0d_max got %h want %h", c, max_out, v[g]); end
`endif
            handoff(1'b1, to);
            n_vec++; if (to) begin n_miss++; $display("FAIL rand%0d_handoff timeout", c); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
